noc_mesh_router: RTL and testbench
==================================

// Module: noc_mesh_router
// PURPOSE
//  Clocked, parametrised 5-port mesh router; successor to the fixed 3x3 four-phase router tile.
//  Single-flit packets, dimension-ordered XY routing, per-input FIFO, round-robin output arbitration.
//  Instantiated once per mesh node; PE attaches to port 0, neighbours and memory to ports 1-4.
// PARAMETERS
//  MY_X        0   node X coordinate (X grows rightwards)
//  MY_Y        0   node Y coordinate (Y grows upwards)
//  MESH_X      3   mesh columns (valid dest_x 0..MESH_X-1)
//  MESH_Y      3   mesh rows (valid dest_y 0..MESH_Y-1)
//  ADDR_W      2   width of each coordinate field
//  DATA_W      29  payload width; FLIT_W = 2*ADDR_W+DATA_W (33 by default)
//  FIFO_DEPTH  4   input FIFO entries per port; power of 2, >=2
// PORTS
//  clk        in   1            clock; all state on rising edge
//  reset      in   1            synchronous, active-high
//  in_valid   in   5            per input port: flit offered
//  in_ready   out  5            per input port: FIFO can accept
//  in_flit    in   5*FLIT_W     port p at [p*FLIT_W +: FLIT_W]
//  out_valid  out  5            per output port: flit held
//  out_ready  in   5            per output port: sink accepts
//  out_flit   out  5*FLIT_W     same packing as in_flit
//  drop_cnt   out  16           only with NOC_BAD_DEST_DROP_EN: dropped flit count
// BEHAVIOUR
//  Port index: 0=PE, 1=left(-X), 2=right(+X), 3=up(+Y), 4=down(-Y).
//  Flit: [FLIT_W-1 -: ADDR_W]=dest_x, next ADDR_W=dest_y, [DATA_W-1:0]=payload; forwarded unmodified.
//  Handshake: transfer when valid&&ready on rising edge; valid never drops until transfer.
//  in_ready[p] = !fifo_full[p]; does not depend on same-cycle dequeue.
//  Route of FIFO head: dest_x>MY_X->2; dest_x<MY_X->1; else dest_y>MY_Y->3; dest_y<MY_Y->4; else 0.
//  Output stage: one register per output. Loads when empty or when out_valid&&out_ready this cycle
//  (full throughput, 1 flit/cycle/output). Winner dequeued from its FIFO on the same edge.
//  Arbitration per output: round-robin over requesting inputs, search from rr_ptr upward with wrap;
//  on grant rr_ptr <= winner+1 (mod 5); no grant -> pointer unchanged. Each input requests one output.
//  Latency: flit accepted at edge N -> out_valid high after edge N+1 (2 cycles min) when uncontended.
//  Order: flits from one input to one output leave in arrival order.
//  Full FIFO: in_ready low; one accepted per edge max. Empty FIFO: no request.
//  Reset: FIFOs flushed, out_valid=0, out_flit=0, rr_ptr=0, in_ready=1 on first cycle after reset;
//  reset mid-transfer discards all held flits; no partial state survives.
// CONFIGURATION
//  NOC_BAD_DEST_DROP_EN defined: head flit with dest_x>=MESH_X or dest_y>=MESH_Y is dequeued in one
//  cycle without output, drop_cnt increments (saturates at 16'hFFFF, reset 0); port drop_cnt exists.
//  Undefined: no check, out-of-mesh flits follow plain XY routing; drop_cnt port absent.
// STRUCTURE
//  noc_pkg: port index constants (P_PE..P_DOWN), NPORT=5, flit field offset functions, route function.
//  Sub-module noc_fifo: synchronous FIFO (WIDTH, DEPTH), full/empty, head visible combinationally.
//  Top: 5x noc_fifo, route decode, 5 round-robin arbiters, 5 output registers.
// TESTING (MY_X=1, MY_Y=1, 3x3, defaults)
//  Reset 3 cycles -> out_valid=5'b0, in_ready=5'b11111, out_flit=0.
//  PE injects dest(2,1) payload 'h5 -> port 2 out_valid 2 cycles later, flit unchanged;
//    dest(1,2)->port 3, (1,0)->port 4, (0,1)->port 1, (1,1)->port 0.
//  Ports 1 and 2 both send dest(1,1) every cycle, out_ready[0]=1 -> port 0 emits 1,2,1,2... no loss.
//  out_ready[2]=0, PE sends 6 flits to (2,0) -> 5 accepted (4 FIFO + 1 out reg), in_ready[0]=0;
//    release out_ready -> 5 flits in order, one per cycle.
//  Reset asserted while 3 flits held -> after reset all out_valid=0, nothing later emitted.
//  NOC_BAD_DEST_DROP_EN: PE sends dest(3,0) then dest(2,0) -> drop_cnt=1, only second flit on port 2.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg - shared definitions for the mesh router.
//   NPORT / P_*       : port indices (0=PE, 1=left -X, 2=right +X, 3=up +Y, 4=down -Y)
//   dest_x_lsb/_y_lsb : bit offsets of the destination fields inside a flit
//   route_xy          : dimension-ordered XY output selection
package noc_pkg;

  localparam int NPORT = 5;

  localparam logic [2:0] P_PE    = 3'd0;
  localparam logic [2:0] P_LEFT  = 3'd1;
  localparam logic [2:0] P_RIGHT = 3'd2;
  localparam logic [2:0] P_UP    = 3'd3;
  localparam logic [2:0] P_DOWN  = 3'd4;

  // Flit layout: {dest_x, dest_y, payload}
  function automatic int dest_x_lsb(int addr_w, int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int dest_y_lsb(int data_w);
    return data_w;
  endfunction

  // X is resolved completely before Y; a flit for this node goes to the PE.
  function automatic logic [2:0] route_xy(int dest_x, int dest_y, int my_x, int my_y);
    if (dest_x > my_x) return P_RIGHT;
    if (dest_x < my_x) return P_LEFT;
    if (dest_y > my_y) return P_UP;
    if (dest_y < my_y) return P_DOWN;
    return P_PE;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// noc_fifo - synchronous FIFO with the head entry visible combinationally.
//   clk, reset : clock, synchronous active-high reset (flushes pointers)
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   dout       : current head entry (meaningful only when !empty)
//   full/empty : occupancy flags
module noc_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit tells full from empty when the indices match.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_mesh_router.sv
// noc_mesh_router - 5-port mesh router tile, single-flit packets, XY routing,
// one FIFO per input, round-robin arbitration and one register per output.
//   clk, reset         : clock, synchronous active-high reset
//   in_valid/in_ready  : per-input handshake (in_ready = FIFO not full)
//   in_flit            : port p at [p*FLIT_W +: FLIT_W]
//   out_valid/out_ready: per-output handshake
//   out_flit           : same packing as in_flit
//   drop_cnt           : saturating count of out-of-mesh flits discarded
//                        (present only with NOC_BAD_DEST_DROP_EN defined)
// Build option NOC_BAD_DEST_DROP_EN: discard head flits whose destination lies
// outside the MESH_X x MESH_Y mesh instead of routing them.
module noc_mesh_router
  import noc_pkg::*;
#(
  parameter int MY_X       = 0,
  parameter int MY_Y       = 0,
  parameter int MESH_X     = 3,
  parameter int MESH_Y     = 3,
  parameter int ADDR_W     = 2,
  parameter int DATA_W     = 29,
  parameter int FIFO_DEPTH = 4,
  localparam int FLIT_W    = 2*ADDR_W + DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NPORT-1:0]        in_valid,
  output logic [NPORT-1:0]        in_ready,
  input  logic [NPORT*FLIT_W-1:0] in_flit,
  output logic [NPORT-1:0]        out_valid,
  input  logic [NPORT-1:0]        out_ready,
  output logic [NPORT*FLIT_W-1:0] out_flit
`ifdef NOC_BAD_DEST_DROP_EN
  ,output logic [15:0]            drop_cnt
`endif
);

  localparam int DX_LSB = dest_x_lsb(ADDR_W, DATA_W);
  localparam int DY_LSB = dest_y_lsb(DATA_W);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      MY_X >= MESH_X || MY_Y >= MESH_Y ||
      MESH_X > (1 << ADDR_W) || MESH_Y > (1 << ADDR_W)) begin : g_param_check
    $error("noc_mesh_router: inconsistent parameters");
  end

  logic [FLIT_W-1:0] head [NPORT];
  logic [NPORT-1:0]  fifo_full;
  logic [NPORT-1:0]  fifo_empty;
  logic [NPORT-1:0]  pop;
  logic [NPORT-1:0]  bad;
  logic [NPORT-1:0]  req [NPORT];     // req[input] = one-hot requested output
  logic [NPORT-1:0]  gnt_acc [NPORT+1];

  assign in_ready = ~fifo_full;

  for (genvar i = 0; i < NPORT; i++) begin : g_in
    logic [ADDR_W-1:0] dx;
    logic [ADDR_W-1:0] dy;
    logic [2:0]        route;

    noc_fifo #(.WIDTH(FLIT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid[i]),
      .pop   (pop[i]),
      .din   (in_flit[i*FLIT_W +: FLIT_W]),
      .dout  (head[i]),
      .full  (fifo_full[i]),
      .empty (fifo_empty[i])
    );

    assign dx    = head[i][DX_LSB +: ADDR_W];
    assign dy    = head[i][DY_LSB +: ADDR_W];
    assign route = route_xy(int'(dx), int'(dy), MY_X, MY_Y);

`ifdef NOC_BAD_DEST_DROP_EN
    assign bad[i] = !fifo_empty[i] && (int'(dx) >= MESH_X || int'(dy) >= MESH_Y);
`else
    assign bad[i] = 1'b0;
`endif

    assign req[i] = (!fifo_empty[i] && !bad[i]) ? (NPORT'(1) << route) : '0;
  end

  assign gnt_acc[0] = '0;

  for (genvar o = 0; o < NPORT; o++) begin : g_out
    logic              vld_q;
    logic [FLIT_W-1:0] flit_q;
    logic [2:0]        ptr_q;
    logic [2:0]        winner;
    logic [2:0]        cand;
    logic              grant;
    logic              load;

    // Output register may take a new flit when empty or draining this cycle.
    assign load = !vld_q || out_ready[o];

    always_comb begin
      cand   = '0;
      grant  = 1'b0;
      winner = ptr_q;
      for (int k = 0; k < NPORT; k++) begin
        cand = (int'(ptr_q) + k >= NPORT) ? 3'(int'(ptr_q) + k - NPORT)
                                          : 3'(int'(ptr_q) + k);
        if (!grant && req[cand][o]) begin
          grant  = 1'b1;
          winner = cand;
        end
      end
    end

    assign gnt_acc[o+1] = gnt_acc[o] | ((load && grant) ? (NPORT'(1) << winner) : '0);

    // The pointer only moves when a flit is actually taken.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q  <= 1'b0;
        flit_q <= '0;
        ptr_q  <= '0;
      end else if (load) begin
        if (grant) begin
          vld_q  <= 1'b1;
          flit_q <= head[winner];
          ptr_q  <= (winner == 3'(NPORT - 1)) ? 3'd0 : winner + 3'd1;
        end else begin
          vld_q  <= 1'b0;
        end
      end
    end

    assign out_valid[o]                   = vld_q;
    assign out_flit[o*FLIT_W +: FLIT_W]   = flit_q;
  end

  // Every input requests one output, so at most one grant reaches each FIFO.
  assign pop = gnt_acc[NPORT] | bad;

`ifdef NOC_BAD_DEST_DROP_EN
  logic [16:0] drop_sum;

  assign drop_sum = {1'b0, drop_cnt} + 17'($countones(bad));

  always_ff @(posedge clk) begin
    if (reset)            drop_cnt <= '0;
    else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
    else                  drop_cnt <= drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_noc_mesh_router.sv
// tb_noc_mesh_router - self-checking bench for noc_mesh_router at node (1,1)
// of a 3x3 mesh. Payload bits [28:26] carry the source port so the scoreboard
// can keep one in-order queue per (input, output) pair.
module tb_noc_mesh_router;

  localparam int FW = 33;
`ifdef NOC_BAD_DEST_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    in_valid = '0;
  logic [4:0]    in_ready;
  logic [5*FW-1:0] in_flit = '0;
  logic [4:0]    out_valid;
  logic [4:0]    out_ready = 5'h1f;
  logic [5*FW-1:0] out_flit;
`ifdef NOC_BAD_DEST_DROP_EN
  logic [15:0]   drop_cnt;
`endif

  noc_mesh_router #(.MY_X(1), .MY_Y(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_flit   (in_flit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flit  (out_flit)
`ifdef NOC_BAD_DEST_DROP_EN
    ,.drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int model_drops = 0;
  int seq = 1000;

  logic [FW-1:0] sbq [25][$];
  logic [4:0]    accepted;
  logic [4:0]    emitted;
  logic [FW-1:0] emit_flit [5];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // XY rule for node (1,1)
  function automatic int exp_port(int dx, int dy);
    if (dx > 1) return 2;
    if (dx < 1) return 1;
    if (dy > 1) return 3;
    if (dy < 1) return 4;
    return 0;
  endfunction

  function automatic logic [FW-1:0] mk(int dx, int dy, int src, int s);
    return {2'(dx), 2'(dy), 3'(src), 26'(s)};
  endfunction

  task automatic drive(input int p, input logic [FW-1:0] f);
    in_valid[p] = 1'b1;
    in_flit[p*FW +: FW] = f;
  endtask

  // Advance one clock; account for every handshake completed on that edge.
  task automatic step();
    logic [4:0]    pir;
    logic [4:0]    pov;
    logic [FW-1:0] pof [5];
    logic          prst;
    logic [FW-1:0] f;
    int            dx, dy, src, key;
    logic          known;
    pir  = in_ready;
    pov  = out_valid;
    prst = reset;
    for (int o = 0; o < 5; o++) pof[o] = out_flit[o*FW +: FW];
    @(posedge clk);
    #1;
    accepted = '0;
    emitted  = '0;
    if (prst) begin
      for (int i = 0; i < 25; i++) sbq[i].delete();
      model_drops = 0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (in_valid[p] && pir[p]) begin
          accepted[p] = 1'b1;
          f  = in_flit[p*FW +: FW];
          dx = int'(f[32:31]);
          dy = int'(f[30:29]);
          if (DROP_EN && (dx >= 3 || dy >= 3)) model_drops++;
          else sbq[p*5 + exp_port(dx, dy)].push_back(f);
        end
      end
      for (int o = 0; o < 5; o++) begin
        if (pov[o] && out_ready[o]) begin
          emitted[o]   = 1'b1;
          emit_flit[o] = pof[o];
          f   = pof[o];
          dx  = int'(f[32:31]);
          dy  = int'(f[30:29]);
          src = int'(f[28:26]);
          check("out_port", o, exp_port(dx, dy));
          key   = src * 5 + o;
          known = (src < 5) && (sbq[key].size() > 0);
          check("out_known", known, 1'b1);
          if (known) check("out_flit", f, sbq[key].pop_front());
        end else if (pov[o]) begin
          check("hold_valid", out_valid[o], 1'b1);
          check("hold_flit", out_flit[o*FW +: FW], pof[o]);
        end
      end
    end
  endtask

  int dxs [5] = '{2, 1, 1, 0, 1};
  int dys [5] = '{1, 2, 0, 1, 1};
  int pts [5] = '{2, 3, 4, 1, 0};

  initial begin
    logic [FW-1:0] f;
    int n, last, src, acc, cnt, total;

    // reset
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check("rst_out_valid", out_valid, 5'b0);
    check("rst_in_ready", in_ready, 5'h1f);
    check("rst_out_flit", out_flit, '0);

    // routing and two-cycle latency
    for (int t = 0; t < 5; t++) begin
      f = mk(dxs[t], dys[t], 0, (t == 0) ? 5 : 100 + t);
      drive(0, f);
      step();
      check("lat_acc", accepted[0], 1'b1);
      in_valid[0] = 1'b0;
      check("lat_early", out_valid, 5'b0);
      step();
      check("lat_valid", out_valid, 5'b1 << pts[t]);
      check("lat_flit", out_flit[pts[t]*FW +: FW], f);
      step();
    end

    // round-robin between ports 1 and 2 into the PE
    drive(1, mk(1, 1, 1, seq++));
    drive(2, mk(1, 1, 2, seq++));
    n = 0;
    last = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      for (int p = 1; p < 3; p++) if (accepted[p]) drive(p, mk(1, 1, p, seq++));
      if (emitted[0]) begin
        src = int'(emit_flit[0][28:26]);
        if (n == 0) check("rr_first", src, 1);
        else        check("rr_alt", src, (last == 1) ? 2 : 1);
        last = src;
        n++;
      end
    end
    in_valid = '0;
    check("rr_rate", n >= 15, 1'b1);
    repeat (12) step();

    // back-pressure on the +X output
    out_ready = 5'b11011;
    acc = 0;
    drive(0, mk(2, 0, 0, seq++));
    for (int c = 0; c < 10; c++) begin
      step();
      if (accepted[0]) begin
        acc++;
        if (acc < 6) drive(0, mk(2, 0, 0, seq++));
        else in_valid[0] = 1'b0;
      end
    end
    check("bp_accepted", acc, 5);
    check("bp_in_ready", in_ready[0], 1'b0);
    in_valid[0] = 1'b0;
    out_ready = 5'h1f;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_burst", emitted[2], 1'b1);
    end
    repeat (3) step();

    // reset while flits are held
    out_ready = '0;
    acc = 0;
    drive(0, mk(2, 1, 0, seq++));
    for (int c = 0; c < 6; c++) begin
      step();
      if (accepted[0]) begin
        acc++;
        if (acc < 3) drive(0, mk(2, 1, 0, seq++));
        else in_valid[0] = 1'b0;
      end
    end
    check("rst_setup", out_valid[2], 1'b1);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    check("rst2_out_valid", out_valid, 5'b0);
    check("rst2_in_ready", in_ready, 5'h1f);
    out_ready = 5'h1f;
    for (int c = 0; c < 5; c++) begin
      step();
      check("rst_quiet", out_valid, 5'b0);
    end

`ifdef NOC_BAD_DEST_DROP_EN
    // out-of-mesh destination is discarded and counted
    cnt = 0;
    drive(0, mk(3, 0, 0, seq++));
    step();
    check("drop_acc1", accepted[0], 1'b1);
    drive(0, mk(2, 0, 0, seq++));
    step();
    check("drop_acc2", accepted[0], 1'b1);
    in_valid[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      cnt += int'(emitted[2]);
    end
    check("drop_one_out", cnt, 1);
    check("drop_cnt", drop_cnt, model_drops);
`endif

    // randomized traffic against the scoreboard
    for (int c = 0; c < 600; c++) begin
      for (int p = 0; p < 5; p++) begin
        if (!in_valid[p] || accepted[p]) begin
          if ($urandom_range(99) < 60)
            drive(p, mk(int'($urandom_range(3)), int'($urandom_range(3)), p, seq++));
          else
            in_valid[p] = 1'b0;
        end
      end
      for (int o = 0; o < 5; o++) out_ready[o] = ($urandom_range(3) != 0);
      step();
    end
    in_valid = '0;
    out_ready = 5'h1f;
    repeat (40) step();
    total = 0;
    for (int i = 0; i < 25; i++) total += sbq[i].size();
    check("drain_left", total, 0);
    check("drain_idle", out_valid, 5'b0);
`ifdef NOC_BAD_DEST_DROP_EN
    check("drop_total", drop_cnt, model_drops);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
